// File: rtl/rca_config.sv
// Load/store queue configuration: default depth, entry layout and FSM states.
package rca_config;

  import riscv_types::*;

  localparam int unsigned LSQ_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      fn3;
    logic            load;
  } lsq_entry_t;

  localparam int unsigned ENTRY_W = $bits(lsq_entry_t);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2
  } lsq_state_e;

endpackage

// File: rtl/riscv_types.sv
// RISC-V load/store funct3 encodings and lane helpers shared by the LSQ.
package riscv_types;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] LS_B_fn3  = 3'b000;
  localparam logic [2:0] LS_H_fn3  = 3'b001;
  localparam logic [2:0] LS_W_fn3  = 3'b010;
  localparam logic [2:0] LS_BU_fn3 = 3'b100;
  localparam logic [2:0] LS_HU_fn3 = 3'b101;

  // Picks the addressed byte/half out of the fetched word and extends it.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                  input logic [1:0]      off,
                                                  input logic [2:0]      f);
    logic [7:0]  b;
    logic [15:0] h;
    logic [XLEN-1:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f)
      LS_B_fn3:  r = {{(XLEN-8){b[7]}}, b};
      LS_BU_fn3: r = {{(XLEN-8){1'b0}}, b};
      LS_H_fn3:  r = {{(XLEN-16){h[15]}}, h};
      LS_HU_fn3: r = {{(XLEN-16){1'b0}}, h};
      default:   r = word;
    endcase
    return r;
  endfunction

  function automatic logic ls_misaligned(input logic [2:0] f, input logic [1:0] off);
    return ((f[1:0] == 2'b01) && off[0]) || ((f[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsq_fifo.sv
// Request storage for the LSQ: circular buffer with occupancy counter.
module lsq_fifo
  import rca_config::*;
#(
  parameter int unsigned DEPTH = LSQ_DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] wr_entry,
  output logic               full,
  output logic               empty,
  output logic [ENTRY_W-1:0] head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/rca_lsq.sv
// Load/store queue: in-order issue of byte/half/word requests to a simple memory port.
// Optional misalignment trap enabled by defining RCA_LSQ_MISALIGN_CHECK_EN.
module rca_lsq
  import riscv_types::*, rca_config::*;
#(
  parameter int unsigned LSQ_DEPTH = LSQ_DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      fn3,
  input  logic            load,
  input  logic            store,
  input  logic            new_request,
  output logic            lsq_full,
  output logic [XLEN-1:0] load_data,
  output logic            load_complete,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  output logic            mem_rnw,
  output logic            mem_req,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid,
  output logic            misaligned_err
);

  lsq_entry_t         wr_entry;
  lsq_entry_t         head;
  logic [ENTRY_W-1:0] head_bits;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  lsq_state_e         state_q;
  lsq_state_e         state_d;
  logic               capture;
  logic [1:0]         pend_off;
  logic [2:0]         pend_fn3;
`ifdef RCA_LSQ_MISALIGN_CHECK_EN
  logic               mis_fire;
`endif

  // A request flagged as both load and store is handled as a store.
  always_comb begin
    wr_entry.addr = addr;
    wr_entry.data = data;
    wr_entry.fn3  = fn3;
    wr_entry.load = load & ~store;
  end

  assign push     = new_request & ~fifo_full;
  assign lsq_full = fifo_full;
  assign head     = lsq_entry_t'(head_bits);

  lsq_fifo #(.DEPTH(LSQ_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head_bits)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // IDLE also looks at this cycle's push so a fresh request issues on the next cycle.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    capture   = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    mem_rnw   = 1'b0;
`ifdef RCA_LSQ_MISALIGN_CHECK_EN
    mis_fire  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty || push) state_d = REQ;
      end
      REQ: begin
`ifdef RCA_LSQ_MISALIGN_CHECK_EN
        if (ls_misaligned(head.fn3, head.addr[1:0])) begin
          pop      = 1'b1;
          mis_fire = 1'b1;
          state_d  = IDLE;
        end else
`endif
        begin
          mem_req  = 1'b1;
          mem_addr = {head.addr[XLEN-1:2], 2'b00};
          mem_rnw  = head.load;
          if (!head.load) begin
            case (head.fn3[1:0])
              2'b00: begin
                mem_be    = 4'b0001 << head.addr[1:0];
                mem_wdata = {4{head.data[7:0]}};
              end
              2'b01: begin
                mem_be    = 4'b0011 << {head.addr[1], 1'b0};
                mem_wdata = {2{head.data[15:0]}};
              end
              default: begin
                mem_be    = 4'b1111;
                mem_wdata = head.data;
              end
            endcase
          end
          if (mem_ack) begin
            pop = 1'b1;
            if (head.load) begin
              capture = 1'b1;
              state_d = WAIT_RESP;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      WAIT_RESP: begin
        if (mem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Lane offset and size are kept because the head has already been popped by response time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_off      <= '0;
      pend_fn3      <= '0;
      load_data     <= '0;
      load_complete <= 1'b0;
    end else begin
      load_complete <= 1'b0;
      if (capture) begin
        pend_off <= head.addr[1:0];
        pend_fn3 <= head.fn3;
      end
      if ((state_q == WAIT_RESP) && mem_rvalid) begin
        load_complete <= 1'b1;
        load_data     <= load_extend(mem_rdata, pend_off, pend_fn3);
      end
`ifdef RCA_LSQ_MISALIGN_CHECK_EN
      if (mis_fire && head.load) begin
        load_complete <= 1'b1;
        load_data     <= '0;
      end
`endif
    end
  end

`ifdef RCA_LSQ_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        misaligned_err <= 1'b0;
    else if (mis_fire) misaligned_err <= 1'b1;
  end
`else
  assign misaligned_err = 1'b0;
`endif

endmodule

// File: tb/tb_rca_lsq.sv
// Self-checking bench for rca_lsq: directed vector table, corner sequences, randomized traffic.
module tb_rca_lsq;
  import riscv_types::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, data;
  logic [2:0]  fn3;
  logic        load, store, new_request;
  logic        lsq_full;
  logic [31:0] load_data;
  logic        load_complete;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rnw, mem_req, mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        misaligned_err;

  rca_lsq #(.LSQ_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data(data), .fn3(fn3),
    .load(load), .store(store), .new_request(new_request),
    .lsq_full(lsq_full), .load_data(load_data), .load_complete(load_complete),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rnw(mem_rnw), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .misaligned_err(misaligned_err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference rules, written directly from the byte-lane arithmetic.
  function automatic logic [3:0] ref_be(input logic [2:0] f, input logic [31:0] a);
    int unsigned off = a % 4;
    if (f[1:0] == 2'b00) return 4'(1 << off);
    if (f[1:0] == 2'b01) return 4'(3 << (2 * (off / 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f, input logic [31:0] d);
    if (f[1:0] == 2'b00) return d[7:0] * 32'h0101_0101;
    if (f[1:0] == 2'b01) return d[15:0] * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] rd);
    int unsigned off = a % 4;
    logic [31:0] v;
    case (f)
      LS_B_fn3, LS_BU_fn3: begin
        v = (rd >> (8 * off)) & 32'hFF;
        if (f == LS_B_fn3 && v >= 128) v = v - 256;
      end
      LS_H_fn3, LS_HU_fn3: begin
        v = (rd >> (16 * (off / 2))) & 32'hFFFF;
        if (f == LS_H_fn3 && v >= 32768) v = v - 65536;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  typedef struct {
    logic [2:0]  fn3;
    logic        ld;
    logic [31:0] addr, data, rdata, exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_ld;
  } vec_t;

  typedef struct {
    logic [2:0]  fn3;
    logic        ld;
    logic [31:0] addr, data;
  } req_t;

  function automatic vec_t mk(input logic [2:0] f, input logic ld, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] rd, input logic [31:0] ea,
                              input logic [3:0] eb, input logic [31:0] ew, input logic [31:0] el);
    vec_t v;
    v.fn3 = f; v.ld = ld; v.addr = a; v.data = d; v.rdata = rd;
    v.exp_addr = ea; v.exp_be = eb; v.exp_wdata = ew; v.exp_ld = el;
    return v;
  endfunction

  task automatic drive_req(input logic [2:0] f, input logic ld, input logic [31:0] a,
                           input logic [31:0] d);
    new_request = 1'b1; fn3 = f; load = ld; store = ~ld; addr = a; data = d;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(mem_req), 32'd1);
  endtask

  // Single request from an idle queue: checks issue latency, lanes and completion.
  task automatic run_vec(input vec_t v, input int idx);
    logic seen;
    drive_req(v.fn3, v.ld, v.addr, v.data);
    @(negedge clk);
    new_request = 1'b0;
    check($sformatf("v%0d_req_latency", idx), 32'(mem_req), 32'd1);
    check($sformatf("v%0d_mem_addr", idx), mem_addr, v.exp_addr);
    check($sformatf("v%0d_mem_rnw", idx), 32'(mem_rnw), 32'(v.ld));
    if (!v.ld) begin
      check($sformatf("v%0d_mem_be", idx), 32'(mem_be), 32'(v.exp_be));
      check($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.exp_wdata);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    if (v.ld) begin
      check($sformatf("v%0d_single_outstanding", idx), 32'(mem_req), 32'd0);
      mem_rvalid = 1'b1; mem_rdata = v.rdata;
      @(negedge clk);
      mem_rvalid = 1'b0;
      check($sformatf("v%0d_load_complete", idx), 32'(load_complete), 32'd1);
      check($sformatf("v%0d_load_data", idx), load_data, v.exp_ld);
      @(negedge clk);
      check($sformatf("v%0d_pulse_width", idx), 32'(load_complete), 32'd0);
      check($sformatf("v%0d_load_data_hold", idx), load_data, v.exp_ld);
    end else begin
      seen = 1'b0;
      repeat (3) begin
        @(negedge clk);
        seen |= load_complete;
      end
      check($sformatf("v%0d_store_no_complete", idx), 32'(seen), 32'd0);
    end
  endtask

  vec_t        vecs[$];
  req_t        ref_q[$];
  logic [31:0] qa[5];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; new_request = 1'b0; load = 1'b0; store = 1'b0;
    addr = '0; data = '0; fn3 = '0; mem_ack = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;

    vecs.push_back(mk(LS_B_fn3,  1'b1, 32'h1003, 32'h0, 32'h80FF_FF00, 32'h1000, 4'h0, 32'h0, 32'hFFFF_FF80));
    vecs.push_back(mk(LS_H_fn3,  1'b0, 32'h2002, 32'h0000_ABCD, 32'h0, 32'h2000, 4'b1100, 32'hABCD_ABCD, 32'h0));
    vecs.push_back(mk(LS_BU_fn3, 1'b1, 32'h1001, 32'h0, 32'h1234_8056, 32'h1000, 4'h0, 32'h0, 32'h0000_0080));
    vecs.push_back(mk(LS_H_fn3,  1'b1, 32'h3002, 32'h0, 32'h9ABC_1234, 32'h3000, 4'h0, 32'h0, 32'hFFFF_9ABC));
    vecs.push_back(mk(LS_HU_fn3, 1'b1, 32'h3000, 32'h0, 32'h9ABC_8765, 32'h3000, 4'h0, 32'h0, 32'h0000_8765));
    vecs.push_back(mk(LS_H_fn3,  1'b1, 32'h3000, 32'h0, 32'h0001_7FFF, 32'h3000, 4'h0, 32'h0, 32'h0000_7FFF));
    vecs.push_back(mk(LS_W_fn3,  1'b1, 32'h4004, 32'h0, 32'hDEAD_BEEF, 32'h4004, 4'h0, 32'h0, 32'hDEAD_BEEF));
    vecs.push_back(mk(LS_B_fn3,  1'b0, 32'h5001, 32'h0000_00A5, 32'h0, 32'h5000, 4'b0010, 32'hA5A5_A5A5, 32'h0));
    vecs.push_back(mk(LS_W_fn3,  1'b0, 32'h6000, 32'h1122_3344, 32'h0, 32'h6000, 4'b1111, 32'h1122_3344, 32'h0));

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_lsq_full", 32'(lsq_full), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_load_complete", 32'(load_complete), 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_misaligned_err", 32'(misaligned_err), 32'd0);
    check("rst_mem_outputs", {mem_addr ^ mem_wdata, 28'(0)} | 32'({mem_be, mem_rnw}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Fill to capacity with stores while the memory stalls
    for (int i = 0; i < 5; i++) qa[i] = 32'h100 + 32'(i) * 32'h10;
    for (int i = 0; i < 5; i++) begin
      drive_req(LS_W_fn3, 1'b0, qa[i], 32'(i));
      @(negedge clk);
      if (i == 2) check("full_after_3", 32'(lsq_full), 32'd0);
      if (i == 3) check("full_after_4", 32'(lsq_full), 32'd1);
      if (i == 4) check("full_after_5th_dropped", 32'(lsq_full), 32'd1);
    end
    new_request = 1'b0;
    check("full_head_addr", mem_addr, qa[0]);
    mem_ack = 1'b1;
    drive_req(LS_W_fn3, 1'b0, 32'h9990, 32'h0);
    @(negedge clk);
    mem_ack = 1'b0; new_request = 1'b0;
    check("full_ack_push_dropped", 32'(lsq_full), 32'd0);
    wait_req("wait_entry1");
    check("order_entry1", mem_addr, qa[1]);
    mem_ack = 1'b1;
    drive_req(LS_W_fn3, 1'b0, 32'hAA0, 32'h0);
    @(negedge clk);
    mem_ack = 1'b0; new_request = 1'b0;
    check("push_pop_count_same", 32'(lsq_full), 32'd0);
    drive_req(LS_W_fn3, 1'b0, 32'hBB0, 32'h0);
    @(negedge clk);
    new_request = 1'b0;
    check("refill_full", 32'(lsq_full), 32'd1);
    qa[0] = qa[2]; qa[1] = qa[3]; qa[2] = 32'hAA0; qa[3] = 32'hBB0;
    for (int i = 0; i < 4; i++) begin
      wait_req($sformatf("drain_wait%0d", i));
      check($sformatf("drain_order%0d", i), mem_addr, qa[i]);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
    end
    begin
      logic seen = 1'b0;
      repeat (4) begin
        @(negedge clk);
        seen |= mem_req;
      end
      check("drain_empty_no_req", 32'(seen), 32'd0);
    end

    // Reset while a load waits for its response, with another load queued
    drive_req(LS_W_fn3, 1'b1, 32'h7000, 32'h0);
    @(negedge clk);
    drive_req(LS_W_fn3, 1'b1, 32'h7100, 32'h0);
    mem_ack = 1'b1;
    @(negedge clk);
    new_request = 1'b0; mem_ack = 1'b0;
    check("midrst_wait_no_req", 32'(mem_req), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_rvalid = 1'b0;
    begin
      logic seen_lc = load_complete;
      logic seen_rq = mem_req;
      repeat (3) begin
        @(negedge clk);
        seen_lc |= load_complete;
        seen_rq |= mem_req;
      end
      check("midrst_late_rvalid_ignored", 32'(seen_lc), 32'd0);
      check("midrst_queue_abandoned", 32'(seen_rq), 32'd0);
    end
    run_vec(mk(LS_W_fn3, 1'b1, 32'h8000, 32'h0, 32'h0BAD_F00D, 32'h8000, 4'h0, 32'h0, 32'h0BAD_F00D), 100);

`ifdef RCA_LSQ_MISALIGN_CHECK_EN
    drive_req(LS_W_fn3, 1'b1, 32'h1001, 32'h0);
    @(negedge clk);
    new_request = 1'b0;
    check("mis_no_req_n1", 32'(mem_req), 32'd0);
    @(negedge clk);
    check("mis_no_req_n2", 32'(mem_req), 32'd0);
    check("mis_load_complete", 32'(load_complete), 32'd1);
    check("mis_load_data_zero", load_data, 32'd0);
    check("mis_err_set", 32'(misaligned_err), 32'd1);
    drive_req(LS_H_fn3, 1'b0, 32'h2001, 32'h1234);
    @(negedge clk);
    new_request = 1'b0;
    begin
      logic seen_lc = 1'b0;
      logic seen_rq = mem_req;
      repeat (3) begin
        @(negedge clk);
        seen_lc |= load_complete;
        seen_rq |= mem_req;
      end
      check("mis_store_no_req", 32'(seen_rq), 32'd0);
      check("mis_store_no_complete", 32'(seen_lc), 32'd0);
    end
`else
    run_vec(mk(LS_W_fn3, 1'b1, 32'h1001, 32'h0, 32'hCAFE_F00D, 32'h1000, 4'h0, 32'h0, 32'hCAFE_F00D), 200);
    run_vec(mk(LS_H_fn3, 1'b0, 32'h2003, 32'h0000_BEEF, 32'h0, 32'h2000, 4'b1100, 32'hBEEF_BEEF, 32'h0), 201);
    check("mis_err_tied_low", 32'(misaligned_err), 32'd0);
`endif

    // Randomized traffic against the queue model
    begin
      logic        pending = 1'b0;
      int          rv_delay = 0;
      req_t        pend_r;
      req_t        r;
      logic        exp_lc = 1'b0;
      logic [31:0] exp_val = '0;
      logic        full_pre;
      logic [2:0]  ld_fns[5];
      ld_fns[0] = LS_B_fn3; ld_fns[1] = LS_H_fn3; ld_fns[2] = LS_W_fn3;
      ld_fns[3] = LS_BU_fn3; ld_fns[4] = LS_HU_fn3;
      pend_r = '{fn3: 3'd0, ld: 1'b0, addr: 32'd0, data: 32'd0};
      for (int cyc = 0; cyc < 2000; cyc++) begin
        @(negedge clk);
        full_pre = (ref_q.size() == 4);
        check("rnd_lsq_full", 32'(lsq_full), 32'(full_pre));
        check("rnd_load_complete", 32'(load_complete), 32'(exp_lc));
        if (exp_lc) check("rnd_load_data", load_data, exp_val);
        if (pending) check("rnd_one_outstanding", 32'(mem_req), 32'd0);
        exp_lc = 1'b0; mem_ack = 1'b0; mem_rvalid = 1'b0; new_request = 1'b0;
        if (pending) begin
          if (rv_delay == 0) begin
            mem_rvalid = 1'b1; mem_rdata = $urandom;
            exp_lc = 1'b1;
            exp_val = ref_load(pend_r.fn3, pend_r.addr, mem_rdata);
            pending = 1'b0;
          end else begin
            rv_delay--;
          end
        end else if (mem_req) begin
          if (ref_q.size() == 0) begin
            check("rnd_req_with_empty_model", 32'(mem_req), 32'd0);
          end else begin
            check("rnd_mem_addr", mem_addr, ref_q[0].addr & ~32'h3);
            check("rnd_mem_rnw", 32'(mem_rnw), 32'(ref_q[0].ld));
            if (!ref_q[0].ld) begin
              check("rnd_mem_be", 32'(mem_be), 32'(ref_be(ref_q[0].fn3, ref_q[0].addr)));
              check("rnd_mem_wdata", mem_wdata, ref_wdata(ref_q[0].fn3, ref_q[0].data));
            end
            if ($urandom_range(1, 0) == 1) begin
              mem_ack = 1'b1;
              if (ref_q[0].ld) begin
                pending = 1'b1;
                rv_delay = int'($urandom_range(2, 0));
                pend_r = ref_q[0];
              end
              void'(ref_q.pop_front());
            end else if ($urandom_range(3, 0) == 0) begin
              mem_rvalid = 1'b1; mem_rdata = $urandom;
            end
          end
        end else if ($urandom_range(7, 0) == 0) begin
          mem_rvalid = 1'b1; mem_rdata = $urandom;
        end
        if (cyc < 1950 && $urandom_range(2, 0) != 0) begin
          r.ld   = 1'($urandom_range(1, 0));
          r.fn3  = r.ld ? ld_fns[$urandom_range(4, 0)] : ld_fns[$urandom_range(2, 0)];
          r.addr = $urandom;
          r.data = $urandom;
`ifdef RCA_LSQ_MISALIGN_CHECK_EN
          if (r.fn3[1:0] == 2'b01) r.addr[0] = 1'b0;
          if (r.fn3[1:0] == 2'b10) r.addr[1:0] = 2'b00;
`endif
          drive_req(r.fn3, r.ld, r.addr, r.data);
          if (!full_pre) ref_q.push_back(r);
        end
      end
      @(negedge clk);
      check("rnd_final_complete", 32'(load_complete), 32'(exp_lc));
      check("rnd_drained", 32'(ref_q.size()), 32'd0);
      check("rnd_no_pending", 32'(pending), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rca_lsq.md
RCA_LSQ -- requirements
Module: rca_lsq

Interface
REQ-001 SHALL have parameter LSQ_DEPTH, default 4, request queue entries (power of 2, >=2).
REQ-002 SHALL have ports clk (in, 1, clock) and rst_n (in, 1, reset); one clock; reset is asynchronous and active-low.
REQ-003 SHALL have addr (in, XLEN, byte address from unit).
REQ-004 SHALL have data (in, XLEN, store data, low bytes significant).
REQ-005 SHALL have fn3 (in, 3, RISC-V load/store funct3).
REQ-006 SHALL have load and store (in, 1 each, request type, one-hot).
REQ-007 SHALL have new_request (in, 1, enqueue strobe).
REQ-008 SHALL have lsq_full (out, 1, queue cannot accept).
REQ-009 SHALL have load_data (out, XLEN, extended load result) and load_complete (out, 1, result-valid pulse).
REQ-010 SHALL have mem_addr (out, XLEN), mem_wdata (out, XLEN), mem_be (out, 4), mem_rnw (out, 1), mem_req (out, 1), mem_ack (in, 1), mem_rdata (in, XLEN), mem_rvalid (in, 1).
REQ-011 SHALL have misaligned_err (out, 1, sticky misalignment flag).

Function
REQ-012 SHALL enqueue {addr, data, fn3, load} on each cycle with new_request=1 and lsq_full=0; new_request while full SHALL be ignored.
REQ-013 lsq_full SHALL equal (count == LSQ_DEPTH), registered-state derived, no combinational path from new_request.
REQ-014 Simultaneous enqueue and dequeue SHALL leave count unchanged; pointers SHALL wrap modulo LSQ_DEPTH.
REQ-015 FSM states IDLE, REQ, WAIT_RESP; IDLE->REQ when queue non-empty; REQ->WAIT_RESP on mem_ack for loads; REQ->IDLE on mem_ack for stores; WAIT_RESP->IDLE on mem_rvalid.
REQ-016 Head entry SHALL dequeue on mem_ack; at most one memory transaction outstanding.
REQ-017 mem_req SHALL be high only in REQ, with mem_addr/mem_wdata/mem_be/mem_rnw stable until mem_ack.
REQ-018 mem_addr SHALL be head addr with bits [1:0] cleared.
REQ-019 Store mem_be: SB 0001<<addr[1:0]; SH 0011<<{addr[1],0}; SW 1111; mem_wdata replicates byte/half across lanes.
REQ-020 Load result: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-021 load_data and load_complete SHALL register one cycle after mem_rvalid in WAIT_RESP; load_complete is a single-cycle pulse; load_data holds until the next completion.
REQ-022 Minimum load latency: enqueue cycle N, mem_req N+1, mem_ack N+1, mem_rvalid N+2, load_complete N+3.
REQ-023 mem_rvalid outside WAIT_RESP SHALL be ignored.
REQ-024 Loads complete in request order; stores produce no completion.

Reset
REQ-025 On rst_n low: count, pointers 0; state IDLE; mem_req, load_complete, misaligned_err 0; load_data 0; other mem outputs 0.
REQ-026 Reset mid-transaction SHALL abandon queued and outstanding requests; late mem_rvalid after release SHALL be ignored.

Configuration
REQ-027 With RCA_LSQ_MISALIGN_CHECK_EN defined, a misaligned head (half at odd, word not 4-aligned) SHALL NOT issue to memory, SHALL dequeue in one cycle, set misaligned_err, and for loads pulse load_complete with load_data 0.
REQ-028 Without RCA_LSQ_MISALIGN_CHECK_EN, no check SHALL occur, misaligned requests issue with addr[1:0] used per REQ-019/020, and misaligned_err SHALL be tied 0.

Structure
REQ-029 lsq_entry_t typedef and LSQ_DEPTH default SHALL live in rca_config; fn3 constants (LS_B_fn3 etc.) SHALL come from riscv_types.
REQ-030 Queue storage SHALL be a sub-module lsq_fifo (push, pop, full, empty, head entry); FSM and alignment logic in rca_lsq.

Verification
REQ-031 LB addr 0x1003, mem_rdata 0x80FF_FF00 -> mem_addr 0x1000, load_data 0xFFFF_FF80, one load_complete pulse.
REQ-032 SH addr 0x2002, data 0x0000_ABCD -> mem_be 1100, mem_wdata 0xABCD_ABCD, mem_rnw 0, no load_complete.
REQ-033 Five back-to-back requests, LSQ_DEPTH 4, mem_ack held low -> lsq_full high after 4th, 5th dropped, count 4.
REQ-034 Full queue, mem_ack and new_request same cycle -> lsq_full stays 0 next cycle only if not refilled, count unchanged, FIFO order preserved.
REQ-035 Reset asserted in WAIT_RESP, then mem_rvalid after release -> no load_complete, state IDLE.
REQ-036 With RCA_LSQ_MISALIGN_CHECK_EN, LW addr 0x1001 -> no mem_req, load_complete with load_data 0, misaligned_err 1.
